as_resettable_register: RTL and testbench
=========================================

AS_RESETTABLE_REGISTER -- requirements
Module: as_resettable_register

Interface
REQ-001 Parameter WIDTH, default 4; data path width in bits; SHALL be >= 1.
REQ-002 Parameter RESET_VALUE, default '0 (all zeros, WIDTH bits); value loaded into q by reset.
REQ-003 Port clk, input, 1 bit; the block's single clock; all state SHALL update on its rising edge only.
REQ-004 Port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 Port en, input, 1 bit; load enable, active-high.
REQ-006 Port d, input, WIDTH bits; data to be captured.
REQ-007 Port q, output, WIDTH bits; registered data output.
REQ-008 Port order SHALL be clk, reset, en, d, q, so positional instantiation works.
REQ-009 The block SHALL have no other ports.

Function
REQ-010 q SHALL be driven directly from a WIDTH-bit register, with no combinational path from any input to q.
REQ-011 At each rising clk edge with reset=1, q SHALL become RESET_VALUE, regardless of en and d.
REQ-012 At each rising clk edge with reset=0 and en=1, q SHALL become the value of d sampled at that edge.
REQ-013 At each rising clk edge with reset=0 and en=0, q SHALL hold its previous value.
REQ-014 Load latency SHALL be one clock: d sampled at edge N SHALL appear on q immediately after edge N.
REQ-015 Changes on reset, en or d between rising edges SHALL NOT affect q until the next rising edge.
REQ-016 Priority SHALL be reset > en > hold.
REQ-017 When reset and en are both high at the same edge, the reset result SHALL win.
REQ-018 reset SHALL NOT clear q asynchronously.
REQ-019 A reset pulse that does not span a rising clk edge SHALL have no effect.
REQ-020 d SHALL be captured bit-for-bit, with no transformation, truncation or extension.
REQ-021 X/Z values on d with en=1 SHALL propagate to q unchanged; the block SHALL NOT sanitise them.

Reset
REQ-022 Before the first rising edge with reset=1, q SHALL be undefined (X in simulation); no initial value is guaranteed.
REQ-023 After one rising edge with reset=1, q SHALL equal RESET_VALUE.
REQ-024 While reset stays high, q SHALL remain RESET_VALUE on every edge.
REQ-025 After reset deasserts, q SHALL remain RESET_VALUE until the first edge with en=1.

Verification
REQ-026 The bench SHALL use a 10-time-unit clock period and drive inputs away from rising edges. WIDTH=4 unless stated.
REQ-027 Scenario: d=4'b1111, en=1, reset=1 for one edge, then reset=0 -> q=4'b0000 after the reset edge; q=4'b1111 after the next edge.
REQ-028 Scenario: q=4'b1111, en=0, d=4'b0000 for 3 edges -> q stays 4'b1111; then en=1 -> q=4'b0000 after the next edge.
REQ-029 Scenario: en=1, d=4'b0001, reset=1 at the same edge -> q=4'b0000 (reset priority).
REQ-030 Scenario: q=4'b1010, reset pulsed high and low entirely between two edges -> q stays 4'b1010.
REQ-031 Scenario: en=1, d stepped 0,1,2,...,15 once per cycle -> q follows d exactly one cycle late.
REQ-032 Scenario: WIDTH=8, RESET_VALUE=8'hA5, reset for one edge -> q=8'hA5; en=1, d=8'h3C -> q=8'h3C after the next edge.

Source files
------------

// File: rtl/as_resettable_register.sv
// Purpose : WIDTH-bit load-enabled register with synchronous, active-high reset to RESET_VALUE.
// Latency : one clock from d sampled at a rising edge to q; q is a pure register output.
// Backpres: none; en=0 simply holds the stored value, so no data is ever refused.
//
// Ports:
//   clk   - single clock; all state changes on its rising edge
//   reset - synchronous active-high reset; wins over en
//   en    - active-high load enable
//   d     - data captured bit-for-bit when en=1
//   q     - registered output

module as_resettable_register #(
    parameter int                   WIDTH       = 4,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // No power-on value is given to q: it stays unknown until the first
    // edge that sees reset high. Reset is only sampled on the edge, so a
    // pulse that falls between two edges leaves q untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: tb/tb_as_resettable_register.sv
// Purpose : directed self-checking bench for as_resettable_register (4-bit default and 8-bit A5 builds).
// Latency : checks q 2 time units after each rising edge; inputs driven on falling edges.
// Backpres: not applicable.

module tb_as_resettable_register;

    logic       clk = 1'b0;
    logic       reset4, en4;
    logic [3:0] d4, q4;
    logic       reset8, en8;
    logic [7:0] d8, q8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    as_resettable_register dut4 (
        .clk   (clk),
        .reset (reset4),
        .en    (en4),
        .d     (d4),
        .q     (q4)
    );

    as_resettable_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
        .clk   (clk),
        .reset (reset8),
        .en    (en8),
        .d     (d8),
        .q     (q8)
    );

    task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Drive the 4-bit DUT on a falling edge, then settle just past the rising edge.
    task automatic step4(input logic r, input logic e, input logic [3:0] dv);
        @(negedge clk);
        reset4 = r;
        en4    = e;
        d4     = dv;
        @(posedge clk);
        #2;
    endtask

    task automatic step8(input logic r, input logic e, input logic [7:0] dv);
        @(negedge clk);
        reset8 = r;
        en8    = e;
        d8     = dv;
        @(posedge clk);
        #2;
    endtask

    initial begin
        reset4 = 1'b0; en4 = 1'b0; d4 = 4'h0;
        reset8 = 1'b0; en8 = 1'b0; d8 = 8'h00;

        // Reset with en=1 and d=F: reset wins, then d loads on the next edge.
        step4(1'b1, 1'b1, 4'hF);
        check_val("rst_clears", {4'h0, q4}, 8'h00);
        step4(1'b0, 1'b1, 4'hF);
        check_val("load_after_rst", {4'h0, q4}, 8'h0F);

        // Hold for three edges with en=0 while d changes, then load.
        for (int i = 0; i < 3; i++) begin
            step4(1'b0, 1'b0, 4'h0);
            check_val($sformatf("hold_%0d", i), {4'h0, q4}, 8'h0F);
        end
        step4(1'b0, 1'b1, 4'h0);
        check_val("load_zero", {4'h0, q4}, 8'h00);

        // Reset and en together at the same edge: reset priority.
        step4(1'b0, 1'b1, 4'h7);
        check_val("load_7", {4'h0, q4}, 8'h07);
        step4(1'b1, 1'b1, 4'h1);
        check_val("rst_over_en", {4'h0, q4}, 8'h00);

        // After reset releases, q keeps the reset value until en rises.
        step4(1'b0, 1'b0, 4'h9);
        check_val("post_rst_hold", {4'h0, q4}, 8'h00);

        // Reset pulse that never spans a rising edge must not disturb q.
        step4(1'b0, 1'b1, 4'hA);
        check_val("load_A", {4'h0, q4}, 8'h0A);
        en4 = 1'b0;
        #1 reset4 = 1'b1;
        #1 reset4 = 1'b0;
        #1;
        check_val("no_async_clr", {4'h0, q4}, 8'h0A);
        step4(1'b0, 1'b0, 4'h3);
        check_val("glitch_ignored", {4'h0, q4}, 8'h0A);

        // Counting ramp: q follows d one edge late.
        for (int i = 0; i < 16; i++) begin
            step4(1'b0, 1'b1, 4'(i));
            check_val($sformatf("ramp_%0d", i), {4'h0, q4}, 8'(i));
        end

        // Mid-cycle d change must wait for the next edge.
        @(negedge clk);
        d4 = 4'h5;
        #1;
        check_val("no_comb_path", {4'h0, q4}, 8'h0F);

        // 8-bit build with non-zero reset value.
        step8(1'b1, 1'b0, 8'h00);
        check_val("rst8_A5", q8, 8'hA5);
        step8(1'b1, 1'b1, 8'hFF);
        check_val("rst8_held", q8, 8'hA5);
        step8(1'b0, 1'b0, 8'h11);
        check_val("rst8_hold_en0", q8, 8'hA5);
        step8(1'b0, 1'b1, 8'h3C);
        check_val("load8_3C", q8, 8'h3C);
        step8(1'b0, 1'b1, 8'hC3);
        check_val("load8_C3", q8, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
